// File: rtl/usb_clk_pkg.sv
// Shared types for the USB clock-generation slice: monitor FSM states and
// counter saturation helpers.
package usb_clk_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARM   = 2'd1,
    MEAS  = 2'd2,
    STUCK = 2'd3
  } mon_state_e;

  function automatic int cnt_max(input int w);
    return (1 << w) - 1;
  endfunction

  localparam int CNT_MAX = cnt_max(5);

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for single-bit or multi-bit level signals crossing
// into the local clock domain.
module sync_2ff #(
  parameter int W = 1
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);

  logic [W-1:0] meta_q;
  logic [W-1:0] sync_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= i_d;
      sync_q <= meta_q;
    end
  end

  assign o_q = sync_q;

endmodule

// File: rtl/clk_ratio_monitor.sv
// Measures period and high time of an asynchronous monitored clock in
// i_ref_clk cycles; reports lock against an expected ratio and stuck clocks.
//   state | meaning
//   IDLE  | disabled, all measurement state cleared
//   ARM   | waiting for first rise; partial period discarded
//   MEAS  | each rise reports period/high and updates lock
//   STUCK | counter saturated without a rise; next rise restarts
module clk_ratio_monitor
  import usb_clk_pkg::*;
#(
  parameter int N        = 4,
  parameter int TOL_W    = 2,
  parameter int LOCK_CNT = 4
) (
  input  logic             i_ref_clk,
  input  logic             i_rst_n,
  input  logic             i_en,
  input  logic             i_mon_clk,
  input  logic [N-1:0]     i_exp_ratio,
  input  logic [TOL_W-1:0] i_tol,
  output logic [N:0]       o_period,
  output logic [N:0]       o_high,
  output logic             o_valid,
  output logic             o_locked,
  output logic             o_duty_ok,
  output logic             o_stuck
);

  localparam int CW = N + 1;
  localparam int GW = $clog2(LOCK_CNT + 1);
  localparam logic [CW-1:0] SAT = CW'(cnt_max(CW));

  mon_state_e    state_q, state_d;
  logic          mon_s;
  logic          mon_prev_q, mon_prev_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] hi_cnt_q, hi_cnt_d;
  logic [GW-1:0] good_cnt_q, good_cnt_d;
  logic [CW-1:0] period_q, period_d;
  logic [CW-1:0] high_q, high_d;
  logic          valid_q, valid_d;
  logic          locked_q, locked_d;
  logic          duty_ok_q, duty_ok_d;
  logic          stuck_q, stuck_d;

  logic                 rise, fall, sat;
  logic signed [N+1:0]  per_err, low_s, duty_err;
  logic        [N+1:0]  per_abs, duty_abs, tol_ext;
  logic                 period_good, duty_good;
  logic        [GW-1:0] good_inc;

  sync_2ff #(.W(1)) u_sync (
    .i_clk   (i_ref_clk),
    .i_rst_n (i_rst_n),
    .i_d     (i_mon_clk),
    .o_q     (mon_s)
  );

  assign rise = mon_s & ~mon_prev_q;
  assign fall = ~mon_s & mon_prev_q;
  assign sat  = (cnt_q == SAT);

  // Differences carried one bit wider than the counts, signed, so they never wrap.
  assign per_err     = $signed({1'b0, cnt_q}) - $signed({2'b00, i_exp_ratio});
  assign per_abs     = per_err[N+1] ? -per_err : per_err;
  assign tol_ext     = {{(N+2-TOL_W){1'b0}}, i_tol};
  assign period_good = (i_exp_ratio >= N'(2)) && (per_abs <= tol_ext);
  assign low_s       = $signed({1'b0, cnt_q}) - $signed({1'b0, hi_cnt_q});
  assign duty_err    = $signed({1'b0, hi_cnt_q}) - low_s;
  assign duty_abs    = duty_err[N+1] ? -duty_err : duty_err;
  assign duty_good   = (duty_abs <= (N+2)'(1));
  assign good_inc    = (good_cnt_q == GW'(LOCK_CNT)) ? good_cnt_q : good_cnt_q + GW'(1);

  always_comb begin
    state_d    = state_q;
    mon_prev_d = mon_s;
    cnt_d      = cnt_q;
    hi_cnt_d   = hi_cnt_q;
    good_cnt_d = good_cnt_q;
    period_d   = period_q;
    high_d     = high_q;
    valid_d    = 1'b0;
    locked_d   = locked_q;
    duty_ok_d  = duty_ok_q;
    stuck_d    = stuck_q;

    if (rise) begin
      cnt_d    = CW'(1);
      hi_cnt_d = '0;
    end else begin
      if (!sat) cnt_d = cnt_q + CW'(1);
      if (fall) hi_cnt_d = cnt_q;
    end

    if (!i_en) begin
      state_d    = IDLE;
      cnt_d      = '0;
      hi_cnt_d   = '0;
      good_cnt_d = '0;
      period_d   = '0;
      high_d     = '0;
      locked_d   = 1'b0;
      duty_ok_d  = 1'b0;
      stuck_d    = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          state_d  = ARM;
          cnt_d    = '0;
          hi_cnt_d = '0;
        end
        ARM: if (rise) state_d = MEAS;
        MEAS: begin
          if (rise) begin
            period_d  = cnt_q;
            high_d    = hi_cnt_q;
            valid_d   = 1'b1;
            duty_ok_d = duty_good;
            if (period_good) begin
              good_cnt_d = good_inc;
              locked_d   = (good_inc == GW'(LOCK_CNT));
            end else begin
              good_cnt_d = '0;
              locked_d   = 1'b0;
            end
          end
        end
        STUCK: if (rise) state_d = MEAS;
        default: state_d = IDLE;
      endcase

      // A rise in the saturating cycle still measures; only a silent saturation is stuck.
      if ((state_q == ARM || state_q == MEAS) && sat && !rise) begin
        state_d    = STUCK;
        stuck_d    = 1'b1;
        locked_d   = 1'b0;
        good_cnt_d = '0;
        period_d   = SAT;
      end
    end
  end

  always_ff @(posedge i_ref_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= IDLE;
      mon_prev_q <= 1'b0;
      cnt_q      <= '0;
      hi_cnt_q   <= '0;
      good_cnt_q <= '0;
      period_q   <= '0;
      high_q     <= '0;
      valid_q    <= 1'b0;
      locked_q   <= 1'b0;
      duty_ok_q  <= 1'b0;
      stuck_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      mon_prev_q <= mon_prev_d;
      cnt_q      <= cnt_d;
      hi_cnt_q   <= hi_cnt_d;
      good_cnt_q <= good_cnt_d;
      period_q   <= period_d;
      high_q     <= high_d;
      valid_q    <= valid_d;
      locked_q   <= locked_d;
      duty_ok_q  <= duty_ok_d;
      stuck_q    <= stuck_d;
    end
  end

  assign o_period  = period_q;
  assign o_high    = high_q;
  assign o_valid   = valid_q;
  assign o_locked  = locked_q;
  assign o_duty_ok = duty_ok_q;
  assign o_stuck   = stuck_q;

endmodule

// File: tb/tb_clk_ratio_monitor.sv
// Directed and randomized bench for clk_ratio_monitor; outputs are compared every
// cycle against a timestamp-based reference model of the measurement rules.
module tb_clk_ratio_monitor;

  localparam int N        = 4;
  localparam int TOL_W    = 2;
  localparam int LOCK_CNT = 4;
  localparam int SATV     = 31;
  localparam int M_IDLE = 0, M_ARM = 1, M_MEAS = 2, M_STUCK = 3;

  logic             clk = 1'b0;
  logic             rst_n, en, mon;
  logic [N-1:0]     exp_ratio;
  logic [TOL_W-1:0] tol;
  logic [N:0]       period, high;
  logic             valid, locked, duty_ok, stuck;

  clk_ratio_monitor #(.N(N), .TOL_W(TOL_W), .LOCK_CNT(LOCK_CNT)) dut (
    .i_ref_clk   (clk),
    .i_rst_n     (rst_n),
    .i_en        (en),
    .i_mon_clk   (mon),
    .i_exp_ratio (exp_ratio),
    .i_tol       (tol),
    .o_period    (period),
    .o_high      (high),
    .o_valid     (valid),
    .o_locked    (locked),
    .o_duty_ok   (duty_ok),
    .o_stuck     (stuck)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: timestamps of the last seen rise/fall, in ref-clock edges.
  int       n_edge = 0;
  int       mode, ref_t, fall_t, run;
  bit       fall_v;
  bit [3:0] hist;
  int       m_period, m_high;
  bit       m_valid, m_locked, m_duty, m_stuck;

  task automatic model_reset();
    mode = M_IDLE; ref_t = 0; fall_t = 0; run = 0; fall_v = 0; hist = '0;
    m_period = 0; m_high = 0; m_valid = 0; m_locked = 0; m_duty = 0; m_stuck = 0;
  endtask

  task automatic model_edge();
    bit rs, fl, good;
    int cnt, hi, err, d;
    n_edge++;
    if (!rst_n) begin
      model_reset();
      return;
    end
    hist = {hist[2:0], mon};
    rs = hist[2] & ~hist[3];
    fl = ~hist[2] & hist[3];
    m_valid = 0;
    if (!en) begin
      model_reset();
      hist = {hist[2:0], 1'b0} | hist;
      return;
    end
    if (mode == M_IDLE) begin
      mode = M_ARM; ref_t = n_edge + 1; fall_v = 0;
    end else begin
      cnt = (n_edge - ref_t > SATV) ? SATV : n_edge - ref_t;
      if (rs) begin
        if (mode == M_MEAS) begin
          hi = !fall_v ? 0 : ((fall_t - ref_t > SATV) ? SATV : fall_t - ref_t);
          m_period = cnt; m_high = hi; m_valid = 1;
          d = 2 * hi - cnt;
          m_duty = (d >= -1 && d <= 1);
          err = cnt - int'(exp_ratio);
          if (err < 0) err = -err;
          good = (exp_ratio >= 2) && (err <= int'(tol));
          run = good ? ((run < LOCK_CNT) ? run + 1 : LOCK_CNT) : 0;
          m_locked = (run == LOCK_CNT);
        end
        mode = M_MEAS; ref_t = n_edge; fall_v = 0;
      end else begin
        if (fl) begin fall_t = n_edge; fall_v = 1; end
        if (mode != M_STUCK && cnt == SATV) begin
          mode = M_STUCK; m_stuck = 1; m_locked = 0; run = 0; m_period = SATV;
        end
      end
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d at edge %0d", tag, obs, expv, n_edge);
    end
  endtask

  task automatic check_all();
    chk("period",  32'(period),  m_period);
    chk("high",    32'(high),    m_high);
    chk("valid",   32'(valid),   32'(m_valid));
    chk("locked",  32'(locked),  32'(m_locked));
    chk("duty_ok", 32'(duty_ok), 32'(m_duty));
    chk("stuck",   32'(stuck),   32'(m_stuck));
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_all();
  endtask

  task automatic mon_run(input int p, input int h, input int n);
    for (int i = 0; i < n; i++)
      for (int c = 0; c < p; c++) begin
        mon = (c < h);
        cycle();
      end
  endtask

  task automatic hold(input int n, input bit v);
    mon = v;
    repeat (n) cycle();
  endtask

  initial begin
    int p, h;
    rst_n = 1'b0; en = 1'b0; mon = 1'b0; exp_ratio = 4'd4; tol = 2'd0;
    model_reset();
    repeat (3) cycle();
    rst_n = 1'b1;
    cycle();
    en = 1'b1;
    hold(6, 1'b0);

    // Divide-by-4, exp 4, tol 0
    mon_run(4, 2, 8);
    chk("t1_locked", 32'(locked), 32'd1);

    // Source switches to /6 while expecting 4
    mon_run(6, 3, 6);
    chk("t3_unlocked", 32'(locked), 32'd0);

    // Divide-by-5 with both duty phases
    exp_ratio = 4'd5;
    mon_run(5, 2, 3);
    mon_run(5, 3, 5);
    chk("t2_locked", 32'(locked), 32'd1);

    // Lock at /4, then stall the clock low, then resume
    exp_ratio = 4'd4;
    mon_run(4, 2, 6);
    hold(40, 1'b0);
    chk("t4_stuck", 32'(stuck), 32'd1);
    chk("t4_period_sat", 32'(period), 32'd31);
    mon_run(4, 2, 6);
    chk("t4_relock", 32'(locked), 32'd1);

    // Ratio ~7.3 with random phase, tol 1 then tol 0
    exp_ratio = 4'd7; tol = 2'd1;
    hold($urandom_range(0, 3), 1'b0);
    for (int i = 0; i < 30; i++) begin
      p = ($urandom_range(0, 9) < 3) ? 8 : 7;
      mon_run(p, $urandom_range(3, 4), 1);
    end
    chk("t5_locked_tol1", 32'(locked), 32'd1);
    tol = 2'd0;
    for (int i = 0; i < 30; i++) begin
      p = ($urandom_range(0, 9) < 3) ? 8 : 7;
      mon_run(p, $urandom_range(3, 4), 1);
    end

    // Random ratios, duty, expectations and tolerances
    for (int i = 0; i < 6; i++) begin
      p = $urandom_range(3, 12);
      h = $urandom_range(1, p - 1);
      exp_ratio = N'($urandom_range(0, 15));
      tol = TOL_W'($urandom_range(0, 3));
      mon_run(p, h, 5);
    end

    // Reset mid-measurement, then run with an invalid expected ratio
    exp_ratio = 4'd4; tol = 2'd0;
    mon_run(4, 2, 3);
    mon = 1'b1;
    cycle();
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all();
    cycle();
    rst_n = 1'b1;
    exp_ratio = 4'd1;
    hold(3, 1'b0);
    mon_run(4, 2, 8);
    chk("t6_ratio1_nolock", 32'(locked), 32'd0);

    // Disable mid-measurement, then re-enable and relock
    exp_ratio = 4'd4;
    mon_run(4, 2, 6);
    mon = 1'b1;
    en = 1'b0;
    cycle();
    chk("t6_en0_period", 32'(period), 32'd0);
    hold(3, 1'b0);
    en = 1'b1;
    hold(4, 1'b0);
    mon_run(4, 2, 8);
    chk("t6_reenable_lock", 32'(locked), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
